if_id_skid_stage: RTL and testbench

Parametrised next-generation IF/ID pipeline register for the pipelined MIPS core. It replaces the bare enable/clear register with a valid/ready handshake and a 2-entry skid buffer, so the fetch stage sees a registered back-pressure signal. Bubbles are explicit as out_valid=0 with NOP payload. Sits between the fetch stage (PC, instruction memory) and decode, and is driven by the hazard unit.

---
 rtl/if_id_pkg.sv | 25 ++
 rtl/sat_counter.sv | 25 ++
 rtl/if_id_skid_stage.sv | 153 +++++++++++++++
 tb/tb_if_id_skid_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared types and constants for the IF/ID skid stage
//
// Purpose : occupancy state encoding, main-register load source select and
//           the default bubble instruction used by if_id_skid_stage.
// Ports   : none (package)
package if_id_pkg;

    // Occupancy of the stage: nothing, main register only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } if_id_state_t;

    // What the main (output) register loads from when it is written.
    typedef enum logic [1:0] {
        SRC_IN     = 2'd0,
        SRC_SKID   = 2'd1,
        SRC_BUBBLE = 2'd2
    } if_id_src_t;

    // sll $0,$0,0 - the canonical MIPS NOP.
    localparam logic [31:0] IF_ID_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose : counts cycles with inc=1, sticks at all-ones, clr has priority.
// Ports   : clk  - rising-edge clock
//           clr  - synchronous clear (active-high)
//           inc  - count enable for this cycle
//           cnt  - current count [W-1:0]
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID pipeline register with valid/ready and 2-entry skid
//
// Purpose : holds fetched instruction + PC+4 for decode. A main register
//           drives the outputs directly; a skid register absorbs the one
//           extra beat that arrives while decode stalls, so in_ready can be
//           a registered function of occupancy. Bubbles are out_valid=0
//           with NOP_INSTR / zero PC+4 on the payload.
// Ports   : clk, rst (sync, active-high), flush (sync squash)
//           in_valid/in_ready/in_instr/in_pc4     - from fetch
//           out_valid/out_ready/out_instr/out_pc4 - to decode
//           stat_stall_cnt/stat_flush_cnt         - only with IF_ID_STAT_EN
// Macro   : IF_ID_STAT_EN adds the saturating stall / flush statistics.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4
`ifdef IF_ID_STAT_EN
    ,
    output logic [31:0]        stat_stall_cnt,
    output logic [31:0]        stat_flush_cnt
`endif
);

    if_id_state_t       state, state_nxt;
    if_id_src_t         main_src;
    logic               main_ld, skid_ld;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic [PC_W-1:0]    main_pc4, skid_pc4;
    logic               in_fire, out_fire;

    // Both handshake outputs decode straight from the state register.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Every path into EMPTY loads the bubble, so the main register already
    // carries NOP / 0 whenever out_valid is low.
    assign out_instr = main_instr;
    assign out_pc4   = main_pc4;

    always_comb begin
        state_nxt = state;
        main_ld   = 1'b0;
        main_src  = SRC_IN;
        skid_ld   = 1'b0;
        if (flush) begin
            // Squash drops everything held and any beat arriving now; a
            // concurrent out_fire is still a completed transfer to decode.
            state_nxt = EMPTY;
            main_ld   = 1'b1;
            main_src  = SRC_BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_ld   = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = TWO;
                        skid_ld   = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                        main_ld   = 1'b1;
                        main_src  = SRC_BUBBLE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain case exists.
                    if (out_fire) begin
                        state_nxt = ONE;
                        main_ld   = 1'b1;
                        main_src  = SRC_SKID;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_ld   = 1'b1;
                    main_src  = SRC_BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_instr <= NOP_INSTR;
            main_pc4   <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
        end else begin
            state <= state_nxt;
            if (main_ld) begin
                case (main_src)
                    SRC_IN: begin
                        main_instr <= in_instr;
                        main_pc4   <= in_pc4;
                    end
                    SRC_SKID: begin
                        main_instr <= skid_instr;
                        main_pc4   <= skid_pc4;
                    end
                    default: begin
                        main_instr <= NOP_INSTR;
                        main_pc4   <= '0;
                    end
                endcase
            end
            if (skid_ld) begin
                skid_instr <= in_instr;
                skid_pc4   <= in_pc4;
            end
        end
    end

`ifdef IF_ID_STAT_EN
    // A flush only counts when it actually discards something.
    sat_counter #(.W(32)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (out_valid & ~out_ready),
        .cnt (stat_stall_cnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (flush & (state != EMPTY)),
        .cnt (stat_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - scoreboard bench for if_id_skid_stage
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc4, out_instr, out_pc4;
`ifdef IF_ID_STAT_EN
    logic [31:0] stat_stall_cnt, stat_flush_cnt;
    int unsigned exp_stall, exp_flush;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Stage contents in arrival order: a capacity-2 FIFO. Accepted beats are
    // pushed when fetch hands them over; the head is what decode must see.
    logic [63:0] exp_q[$];
    bit          armed = 0;

    always #5 clk = ~clk;

    if_id_skid_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc4   (out_pc4)
`ifdef IF_ID_STAT_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_flush_cnt (stat_flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, compares against the FIFO model,
    // then advances the model to what the coming rising edge must do.
    always @(negedge clk) begin
        bit m_in_fire, m_out_fire;
        if (armed) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (exp_q.size() > 0)
                chk("out_payload", {out_instr, out_pc4}, exp_q[0]);
            else
                chk("bubble_payload", {out_instr, out_pc4}, 64'h0);
`ifdef IF_ID_STAT_EN
            chk("stat_stall", 64'(stat_stall_cnt), 64'(exp_stall));
            chk("stat_flush", 64'(stat_flush_cnt), 64'(exp_flush));
`endif
        end
        m_out_fire = (exp_q.size() > 0) && out_ready;
        m_in_fire  = (exp_q.size() < 2) && in_valid;
        if (rst) begin
            exp_q.delete();
            armed = 1;
`ifdef IF_ID_STAT_EN
            exp_stall = 0;
            exp_flush = 0;
`endif
        end else begin
`ifdef IF_ID_STAT_EN
            if (exp_q.size() > 0 && !out_ready) exp_stall++;
            if (flush && exp_q.size() > 0) exp_flush++;
`endif
            if (m_out_fire) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (m_in_fire) exp_q.push_back({in_instr, in_pc4});
        end
    end

    // Drive one cycle of inputs, then step past the rising edge.
    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy);
        rst = r; flush = f; in_valid = iv; in_instr = ins; in_pc4 = pc; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc4 = '0;

        // Reset held while fetch offers an instruction, then release.
        drive(1, 0, 1, 32'h2010_0005, 32'h4, 1);
        drive(1, 0, 1, 32'h2010_0005, 32'h4, 1);
        drive(0, 0, 1, 32'h2010_0005, 32'h4, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Back-to-back streaming with decode always ready.
        for (int i = 1; i <= 8; i++)
            drive(0, 0, 1, 32'h2000_0000 + 32'(i), 32'(4 * i), 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Decode stall for 3 cycles while fetch offers A, B, C; C is held by
        // fetch until the stage takes it.
        drive(0, 0, 1, 32'hAAAA_0001, 32'h100, 0);
        drive(0, 0, 1, 32'hBBBB_0002, 32'h104, 0);
        drive(0, 0, 1, 32'hCCCC_0003, 32'h108, 0);
        drive(0, 0, 1, 32'hCCCC_0003, 32'h108, 1);
        drive(0, 0, 1, 32'hCCCC_0003, 32'h108, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Fill both entries, then flush with a beat in flight.
        drive(0, 0, 1, 32'h1111_0001, 32'h200, 0);
        drive(0, 0, 1, 32'h2222_0002, 32'h204, 0);
        drive(0, 1, 1, 32'h3333_0003, 32'h208, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 0);

        // Flush and reset together with decode consuming.
        drive(0, 0, 1, 32'h4444_0004, 32'h20C, 1);
        drive(1, 1, 1, 32'h5555_0005, 32'h210, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Flush on an empty stage, then a second real flush in ONE.
        drive(0, 1, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 1, 32'h6666_0006, 32'h214, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        drive(0, 1, 0, 32'h0, 32'h0, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7), $urandom, $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 9) < 6));

        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
